pe_ctrl_sequencer: RTL and testbench

//  Drives the packed PE control word and src_2_sel; it is the transmitter for the PE ctrl-bus receiver.
//  Per job: for each of N outputs, issues L MAC cycles reading the PE buffer, then one write-back/flush cycle.

---
 rtl/pe_ctrl_sequencer_pkg.sv | 41 ++++
 rtl/pe_ctrl_sequencer_addr.sv | 20 ++
 rtl/pe_ctrl_sequencer.sv | 121 ++++++++++++
 tb/tb_pe_ctrl_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pe_ctrl_sequencer_pkg.sv
// pe_ctrl_sequencer_pkg: shared widths, op codes, ctrl-word field offsets, states and the ctrl packer.
// The PE ctrl-bus receiver unpacks with the same offsets that pack_ctrl packs with.
package pe_ctrl_sequencer_pkg;
    localparam int PE_BUF_ADDR_WIDTH = 10;
    localparam int ACC_LEN_WIDTH     = 8;
    localparam int OP_CODE_WIDTH     = 3;
    localparam int CTRL_WIDTH        = 2 * PE_BUF_ADDR_WIDTH + 7 + OP_CODE_WIDTH;
    localparam logic [OP_CODE_WIDTH-1:0] OP_NOP = 3'd0;
    localparam logic [OP_CODE_WIDTH-1:0] OP_MAC = 3'd1;
    localparam int OP_CODE_LSB     = 0;
    localparam int ENABLE_BIT      = OP_CODE_WIDTH;
    localparam int RD_REQ_BIT      = OP_CODE_WIDTH + 1;
    localparam int WR_REQ_BIT      = OP_CODE_WIDTH + 2;
    localparam int WRITE_VALID_BIT = OP_CODE_WIDTH + 3;
    localparam int FLUSH_BIT       = OP_CODE_WIDTH + 4;
    localparam int WR_ADDR_LSB     = OP_CODE_WIDTH + 5;
    localparam int RD_ADDR_LSB     = WR_ADDR_LSB + PE_BUF_ADDR_WIDTH;
    localparam int POP_BIT         = RD_ADDR_LSB + PE_BUF_ADDR_WIDTH;
    localparam int PUSH_BIT        = POP_BIT + 1;
    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_WB,
        S_DRAIN,
        S_DONE
    } state_t;
    function automatic logic [CTRL_WIDTH-1:0] pack_ctrl(
        input logic                         push,
        input logic                         pop,
        input logic [PE_BUF_ADDR_WIDTH-1:0] rd,
        input logic [PE_BUF_ADDR_WIDTH-1:0] wr,
        input logic                         flush,
        input logic                         wv,
        input logic                         wreq,
        input logic                         rreq,
        input logic                         en,
        input logic [OP_CODE_WIDTH-1:0]     op
    );
        return {push, pop, rd, wr, flush, wv, wreq, rreq, en, op};
    endfunction
endpackage

// File: rtl/pe_ctrl_sequencer_addr.sv
// pe_addr_counter: loadable PE buffer address counter that wraps modulo 2^PE_BUF_ADDR_WIDTH.
//  clk, reset : clock, synchronous active-high reset (addr -> 0)
//  load, base : load base as the next address (wins over inc)
//  inc        : advance the address by one
//  addr       : current address
module pe_addr_counter
    import pe_ctrl_sequencer_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic                         inc,
    input  logic [PE_BUF_ADDR_WIDTH-1:0] base,
    output logic [PE_BUF_ADDR_WIDTH-1:0] addr
);
    always_ff @(posedge clk)
        if (reset) addr <= '0;
        else if (load) addr <= base;
        else if (inc) addr <= addr + PE_BUF_ADDR_WIDTH'(1);
endmodule

// File: rtl/pe_ctrl_sequencer.sv
// pe_ctrl_sequencer: per job, issues L MAC read cycles then one write-back cycle for each of N outputs.
//  clk, reset      : clock, synchronous active-high reset
//  start           : job start, accepted only in IDLE and not under stall
//  cfg_num_out     : N outputs (0..2^ADDR)      cfg_acc_len : L MAC cycles per output (0 acts as 1)
//  cfg_rd_base     : first read address         cfg_wr_base : first write address
//  cfg_src_2_sel   : operand-2 select           stall       : freezes state, counters and ctrl
//  ctrl            : registered packed PE control word
//  src_2_sel, busy, done : latched select, job-in-flight flag, one-cycle end pulse
//  Optional macro PE_CTRL_NORM_FIFO_EN: push on every WB and a DRAIN of N pop cycles before DONE.
module pe_ctrl_sequencer
    import pe_ctrl_sequencer_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [PE_BUF_ADDR_WIDTH:0]   cfg_num_out,
    input  logic [ACC_LEN_WIDTH-1:0]     cfg_acc_len,
    input  logic [PE_BUF_ADDR_WIDTH-1:0] cfg_rd_base,
    input  logic [PE_BUF_ADDR_WIDTH-1:0] cfg_wr_base,
    input  logic                         cfg_src_2_sel,
    input  logic                         stall,
    output logic [CTRL_WIDTH-1:0]        ctrl,
    output logic                         src_2_sel,
    output logic                         busy,
    output logic                         done
);
`ifdef PE_CTRL_NORM_FIFO_EN
    localparam logic NORM = 1'b1;
`else
    localparam logic NORM = 1'b0;
`endif
    state_t state, state_nxt;
    logic [PE_BUF_ADDR_WIDTH:0]   n_q, out_idx, out_idx_nxt;
    logic [ACC_LEN_WIDTH-1:0]     l_q, acc_cnt, acc_cnt_nxt;
    logic [PE_BUF_ADDR_WIDTH-1:0] rd_addr, wr_addr;
    logic [CTRL_WIDTH-1:0]        ctrl_nxt;
    logic                         accept, rd_inc, wr_inc, last_out;
    assign accept   = state == S_IDLE && start && !stall;
    assign last_out = out_idx == n_q - (PE_BUF_ADDR_WIDTH + 1)'(1);
    // Reads across outputs are contiguous, so rd_base + out_idx*L + acc_cnt is just a running counter.
    pe_addr_counter u_rd (
        .clk(clk), .reset(reset), .load(accept), .inc(rd_inc && !stall),
        .base(cfg_rd_base), .addr(rd_addr)
    );
    pe_addr_counter u_wr (
        .clk(clk), .reset(reset), .load(accept), .inc(wr_inc && !stall),
        .base(cfg_wr_base), .addr(wr_addr)
    );
    always_comb begin
        state_nxt   = state;
        out_idx_nxt = out_idx;
        acc_cnt_nxt = acc_cnt;
        ctrl_nxt    = '0;
        rd_inc      = 1'b0;
        wr_inc      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt   = cfg_num_out == '0 ? S_DONE : S_ACC;
                    out_idx_nxt = '0;
                    acc_cnt_nxt = '0;
                end
            end
            S_ACC: begin
                ctrl_nxt    = pack_ctrl(1'b0, 1'b0, rd_addr, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, OP_MAC);
                rd_inc      = 1'b1;
                acc_cnt_nxt = acc_cnt + ACC_LEN_WIDTH'(1);
                state_nxt   = acc_cnt == l_q - ACC_LEN_WIDTH'(1) ? S_WB : S_ACC;
            end
            S_WB: begin
                ctrl_nxt    = pack_ctrl(NORM, 1'b0, '0, wr_addr, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, OP_NOP);
                wr_inc      = 1'b1;
                acc_cnt_nxt = '0;
`ifdef PE_CTRL_NORM_FIFO_EN
                state_nxt   = last_out ? S_DRAIN : S_ACC;
                out_idx_nxt = last_out ? '0 : out_idx + (PE_BUF_ADDR_WIDTH + 1)'(1);
`else
                state_nxt   = last_out ? S_DONE : S_ACC;
                out_idx_nxt = out_idx + (PE_BUF_ADDR_WIDTH + 1)'(1);
`endif
            end
`ifdef PE_CTRL_NORM_FIFO_EN
            S_DRAIN: begin
                ctrl_nxt    = pack_ctrl(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OP_NOP);
                state_nxt   = last_out ? S_DONE : S_DRAIN;
                out_idx_nxt = out_idx + (PE_BUF_ADDR_WIDTH + 1)'(1);
            end
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end
    // Under stall everything holds except done, so a held DONE state releases its pulse only once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            out_idx   <= '0;
            acc_cnt   <= '0;
            n_q       <= '0;
            l_q       <= '0;
            ctrl      <= '0;
            src_2_sel <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (stall) begin
            done <= 1'b0;
        end else begin
            state   <= state_nxt;
            out_idx <= out_idx_nxt;
            acc_cnt <= acc_cnt_nxt;
            ctrl    <= ctrl_nxt;
            done    <= state == S_DONE;
            busy    <= state_nxt != S_IDLE || state == S_DONE;
            if (accept) begin
                n_q       <= cfg_num_out;
                l_q       <= cfg_acc_len == '0 ? ACC_LEN_WIDTH'(1) : cfg_acc_len;
                src_2_sel <= cfg_src_2_sel;
            end
        end
    end
endmodule

// File: tb/tb_pe_ctrl_sequencer.sv
// tb_pe_ctrl_sequencer: directed and randomized jobs checked against a per-job expected ctrl-word stream.
module tb_pe_ctrl_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] cfg_num_out = '0;
    logic [7:0]  cfg_acc_len = '0;
    logic [9:0]  cfg_rd_base = '0;
    logic [9:0]  cfg_wr_base = '0;
    logic        cfg_src_2_sel = 1'b0;
    logic        stall = 1'b0;
    logic [29:0] ctrl;
    logic        src_2_sel, busy, done;
    int n_cmp = 0;
    int n_err = 0;
`ifdef PE_CTRL_NORM_FIFO_EN
    localparam bit NORM = 1'b1;
`else
    localparam bit NORM = 1'b0;
`endif
    pe_ctrl_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .cfg_num_out(cfg_num_out),
        .cfg_acc_len(cfg_acc_len), .cfg_rd_base(cfg_rd_base), .cfg_wr_base(cfg_wr_base),
        .cfg_src_2_sel(cfg_src_2_sel), .stall(stall), .ctrl(ctrl), .src_2_sel(src_2_sel),
        .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask
    // Fields from MSB: push, pop, rd[9:0], wr[9:0], flush, write_valid, wr_req, rd_req, enable, op[2:0]
    function automatic logic [29:0] word(input bit push, input bit pop, input int rd, input int wr,
                                         input bit fl, input bit wv, input bit wq, input bit rq,
                                         input bit en, input int op);
        logic [29:0] w;
        w = '0;
        w[29] = push;
        w[28] = pop;
        w[27:18] = rd[9:0];
        w[17:8] = wr[9:0];
        w[7] = fl;
        w[6] = wv;
        w[5] = wq;
        w[4] = rq;
        w[3] = en;
        w[2:0] = op[2:0];
        return w;
    endfunction
    task automatic run_job(input int n, input int l, input int rd, input int wr, input bit sel,
                           input int stall_at, input int stall_len, input int stall_pct, input bit poke);
        logic [29:0] q[$];
        logic [29:0] exp_ctrl;
        int le, t, pos, cyc;
        bit stl, stl_prev;
        le = l == 0 ? 1 : l;
        for (int o = 0; o < n; o++) begin
            for (int a = 0; a < le; a++) q.push_back(word(0, 0, (rd + o * le + a) % 1024, 0, 0, 0, 0, 1, 1, 1));
            q.push_back(word(NORM, 0, 0, (wr + o) % 1024, 1, 1, 1, 0, 0, 0));
        end
        if (NORM) for (int o = 0; o < n; o++) q.push_back(word(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        t = q.size() + 2;
        cfg_num_out = 11'(n);
        cfg_acc_len = 8'(l);
        cfg_rd_base = 10'(rd);
        cfg_wr_base = 10'(wr);
        cfg_src_2_sel = sel;
        stall = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        pos = 1;
        cyc = 1;
        stl_prev = 1'b0;
        exp_ctrl = '0;
        while (pos <= t + 1 && cyc < 5000) begin
            if (!stl_prev) exp_ctrl = (pos >= 2 && pos - 2 < q.size()) ? q[pos-2] : '0;
            chk("ctrl", 32'(ctrl), 32'(exp_ctrl));
            chk("done", 32'(done), 32'(!stl_prev && pos == t));
            chk("busy", 32'(busy), 32'(pos >= 1 && pos <= t));
            chk("src_2_sel", 32'(src_2_sel), 32'(sel));
            stl = pos < t && ((cyc >= stall_at && cyc < stall_at + stall_len) ||
                              $urandom_range(99) < 32'(stall_pct));
            if (poke && pos <= t - 2) begin
                cfg_num_out = 11'($urandom_range(7));
                cfg_acc_len = 8'($urandom_range(7));
                cfg_rd_base = 10'($urandom_range(1023));
                cfg_wr_base = 10'($urandom_range(1023));
                cfg_src_2_sel = 1'($urandom_range(1));
                start = 1'($urandom_range(1));
            end
            stall = stl;
            @(posedge clk);
            #1;
            start = 1'b0;
            stall = 1'b0;
            if (!stl) pos++;
            stl_prev = stl;
            cyc++;
        end
        n_cmp++;
        assert (cyc < 5000) else begin
            n_err++;
            $error("FAIL job_timeout observed_pos=%0d expected_end=%0d", pos, t + 1);
        end
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_ctrl", 32'(ctrl), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_sel", 32'(src_2_sel), 32'h0);
        run_job(2, 3, 0, 100, 0, 0, 0, 0, 0);
        run_job(2, 3, 0, 100, 1, 7, 4, 0, 0);
        run_job(0, 3, 5, 9, 1, 0, 0, 0, 0);
        run_job(3, 0, 17, 200, 0, 0, 0, 0, 0);
        run_job(1, 4, 1022, 1023, 1, 0, 0, 0, 0);
        run_job(2, 3, 40, 60, 0, 0, 0, 0, 1);
        run_job(3, 2, 500, 1020, 1, 0, 0, 0, 0);
        cfg_num_out = 11'd2;
        cfg_acc_len = 8'd3;
        cfg_rd_base = 10'd0;
        cfg_wr_base = 10'd100;
        cfg_src_2_sel = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_ctrl", 32'(ctrl), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_sel", 32'(src_2_sel), 32'h0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", 32'(done), 32'h0);
            chk("abort_idle_ctrl", 32'(ctrl), 32'h0);
        end
        run_job(2, 3, 0, 100, 0, 0, 0, 0, 0);
        for (int j = 0; j < 10; j++)
            run_job($urandom_range(6), $urandom_range(6), $urandom_range(1023), $urandom_range(1023),
                    1'($urandom_range(1)), $urandom_range(2, 12), $urandom_range(3), 20, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
